// File: rtl/mcpu_pkg.sv
// Shared constants for the mcpu memory/boot subsystem: default geometry and
// FSM state encoding.
package mcpu_pkg;

    localparam int AW      = 6;
    localparam int DW      = 8;
    localparam int IO_ADDR = 63;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CLEAR = 2'd1;
    localparam state_t ST_LOAD  = 2'd2;
    localparam state_t ST_RUN   = 2'd3;

endpackage

// File: rtl/mcpu_memsys_if.sv
// Core data bus, loader stream and IO pins of the mcpu memory subsystem.
// The slave side is the memsys block; the master side is the core/loader.
interface mcpu_memsys_if #(
    parameter int AW = mcpu_pkg::AW,
    parameter int DW = mcpu_pkg::DW
);
    import mcpu_pkg::*;

    logic          cpu_rst;
    logic [AW-1:0] cpu_adress;
    logic [DW-1:0] cpu_dataout;
    logic          cpu_oe;
    logic          cpu_we;
    logic [DW-1:0] cpu_datain;
    logic          ld_start;
    logic [AW:0]   ld_len;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_busy;
    logic [DW-1:0] io_out;
    logic          io_stb;

    modport slave (
        output cpu_rst, cpu_datain, ld_ready, ld_busy, io_out, io_stb,
        input  cpu_adress, cpu_dataout, cpu_oe, cpu_we,
        input  ld_start, ld_len, ld_valid, ld_data
    );

    modport master (
        input  cpu_rst, cpu_datain, ld_ready, ld_busy, io_out, io_stb,
        output cpu_adress, cpu_dataout, cpu_oe, cpu_we,
        output ld_start, ld_len, ld_valid, ld_data
    );

endinterface

// File: rtl/mcpu_ram64.sv
// Unified program/data RAM: combinational read, one synchronous write port.
// Contents are deliberately not reset.
module mcpu_ram64 #(
    parameter int AW = mcpu_pkg::AW,
    parameter int DW = mcpu_pkg::DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    import mcpu_pkg::*;

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/mcpu_memsys.sv
// Memory and boot subsystem of the mcpu core: program loader FSM, RAM write
// arbitration, core reset control and the memory-mapped output port.
//
//  state | meaning
//  IDLE  | after reset, core held in reset, waiting for ld_start
//  CLEAR | zeroing all RAM locations, one per cycle
//  LOAD  | accepting ld_len bytes from the loader into RAM[0..]
//  RUN   | core released; core writes go to RAM and io_out
module mcpu_memsys #(
    parameter int AW       = mcpu_pkg::AW,
    parameter int DW       = mcpu_pkg::DW,
    parameter int IO_ADDR  = mcpu_pkg::IO_ADDR,
    parameter int CLEAR_EN = 1
) (
    input  logic clk,
    input  logic rst,
    mcpu_memsys_if.slave bus
);
    import mcpu_pkg::*;

    localparam logic [AW:0]   DEPTH   = (AW+1)'(2**AW);
    localparam logic [AW-1:0] LAST    = '1;
    localparam logic [AW-1:0] IO_A    = AW'(IO_ADDR);
    localparam state_t        ST_FILL = (CLEAR_EN != 0) ? ST_CLEAR : ST_LOAD;

    state_t        state, state_nx;
    logic [AW:0]   cnt;
    logic [AW:0]   len;
    logic          cpu_rst_q;
    logic [DW-1:0] io_out_q;
    logic          io_stb_q;

    logic          cpu_wr;
    logic          io_wr;
    logic          ready;
    logic          accept;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_wd;
    logic [DW-1:0] ram_rd;

    // The RAM write flop samples cpu_we on the rising edge, i.e. the value
    // the core held during the preceding clk-low phase.
    assign cpu_wr = (state == ST_RUN) && !bus.cpu_we;
    assign io_wr  = cpu_wr && (bus.cpu_adress == IO_A);
    assign ready  = (state == ST_LOAD) && (cnt < len);
    assign accept = ready && bus.ld_valid;

    always_comb begin
        ram_we = 1'b0;
        ram_wa = cnt[AW-1:0];
        ram_wd = '0;
        case (state)
            ST_CLEAR: ram_we = 1'b1;
            ST_LOAD: begin
                ram_we = accept;
                ram_wd = bus.ld_data;
            end
            ST_RUN: begin
                ram_we = cpu_wr;
                ram_wa = bus.cpu_adress;
                ram_wd = bus.cpu_dataout;
            end
            default: ram_we = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (bus.ld_start) state_nx = ST_FILL;
            ST_CLEAR: if (cnt[AW-1:0] == LAST) state_nx = ST_LOAD;
            ST_LOAD:  if (cnt == len) state_nx = ST_RUN;
            ST_RUN:   if (bus.ld_start) state_nx = ST_FILL;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            len       <= '0;
            cpu_rst_q <= 1'b0;
            io_out_q  <= '0;
            io_stb_q  <= 1'b0;
        end else begin
            state     <= state_nx;
            cpu_rst_q <= (state_nx == ST_RUN);
            io_stb_q  <= io_wr;
            if (io_wr) begin
                io_out_q <= bus.cpu_dataout;
            end
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (bus.ld_start) begin
                        cnt <= '0;
                        len <= (bus.ld_len > DEPTH) ? DEPTH : bus.ld_len;
                    end
                end
                ST_CLEAR: cnt <= (cnt[AW-1:0] == LAST) ? '0 : cnt + 1'b1;
                ST_LOAD:  if (accept) cnt <= cnt + 1'b1;
                default:  cnt <= cnt;
            endcase
        end
    end

    mcpu_ram64 #(.AW(AW), .DW(DW)) u_ram (
        .clk (clk),
        .we  (ram_we),
        .wa  (ram_wa),
        .wd  (ram_wd),
        .ra  (bus.cpu_adress),
        .rd  (ram_rd)
    );

    assign bus.cpu_datain = ram_rd;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.ld_ready   = ready;
    assign bus.ld_busy    = (state == ST_CLEAR) || (state == ST_LOAD);
    assign bus.io_out     = io_out_q;
    assign bus.io_stb     = io_stb_q;

endmodule

// File: tb/tb_mcpu_memsys.sv
// Randomized bench for mcpu_memsys: a RAM image model plus scoreboard queues
// for IO strobes and RAM reads, checked by an independent negedge monitor.
module tb_mcpu_memsys;
    import mcpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mcpu_memsys_if #(.AW(AW), .DW(DW)) bus ();

    mcpu_memsys #(.AW(AW), .DW(DW), .IO_ADDR(IO_ADDR), .CLEAR_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cycles   = 0;

    logic [7:0] model [64];
    logic [7:0] io_q [$];
    logic [7:0] rd_q [$];
    int         rd_a_q [$];
    logic       rd_req = 1'b0;
    logic [7:0] ld_bytes [$];
    int         ld_gaps [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents an IO strobe or a read is requested.
    always @(negedge clk) begin
        cycles++;
        if (cycles > 40000) begin
            $display("FAIL watchdog: cycles %0d exceeded limit 40000", cycles);
            $fatal(1, "bench timeout");
        end
        if (rst) begin
            if (bus.io_stb === 1'b1) begin
                if (io_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL io_stb: strobe with io_out=0x%0h but no IO write expected", bus.io_out);
                end else begin
                    check("io_out", bus.io_out, io_q.pop_front());
                end
            end
            if (rd_req) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd: read requested with no expectation queued");
                end else begin
                    int a;
                    a = rd_a_q.pop_front();
                    check($sformatf("ram[%0d]", a), bus.cpu_datain, rd_q.pop_front());
                end
            end
        end
    end

    task automatic verify_all;
        for (int a = 0; a < 64; a++) begin
            bus.cpu_adress = 6'(a);
            bus.cpu_oe     = 1'b0;
            rd_q.push_back(model[a]);
            rd_a_q.push_back(a);
            rd_req = 1'b1;
            tick;
        end
        rd_req     = 1'b0;
        bus.cpu_oe = 1'b1;
    endtask

    task automatic cpu_store(input int a, input logic [7:0] d, input bit commit);
        bus.cpu_adress  = 6'(a);
        bus.cpu_dataout = d;
        bus.cpu_we      = 1'b0;
        if (commit && a == IO_ADDR) io_q.push_back(d);
        tick;
        bus.cpu_we = 1'b1;
        if (commit) model[a] = d;
        tick;
    endtask

    // Full load: clear image, feed min(len,64) bytes with gaps, expect RUN.
    task automatic do_load(input int len, input bit poke, input bit io_wr, input logic [7:0] io_d);
        int eff;
        int n;
        int g;
        logic [7:0] b;
        eff = (len > 64) ? 64 : len;
        bus.ld_start = 1'b1;
        bus.ld_len   = 7'(len);
        if (io_wr) begin
            bus.cpu_adress  = 6'(IO_ADDR);
            bus.cpu_dataout = io_d;
            bus.cpu_we      = 1'b0;
            io_q.push_back(io_d);
        end
        tick;
        bus.ld_start = 1'b0;
        bus.cpu_we   = 1'b1;
        bus.ld_len   = 7'($urandom_range(0, 127));
        check("cpu_rst_after_start", bus.cpu_rst, 0);
        check("busy_after_start", bus.ld_busy, 1);
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        if (eff == 0) begin
            n = 0;
            while (bus.cpu_rst !== 1'b1 && n < 200) begin
                check("len0_ready", bus.ld_ready, 0);
                tick;
                n++;
            end
            check("len0_cycles_to_run", n, 65);
            return;
        end
        n = 0;
        while (bus.ld_ready !== 1'b1 && n < 200) begin
            bus.ld_start = poke && (n == 10);
            bus.ld_len   = 7'd1;
            tick;
            n++;
        end
        bus.ld_start = 1'b0;
        check("clear_cycles", n, 64);
        for (int i = 0; i < eff; i++) begin
            g = (i < ld_gaps.size()) ? ld_gaps[i] : int'($urandom_range(0, 3));
            b = (i < ld_bytes.size()) ? ld_bytes[i] : 8'($urandom);
            bus.ld_valid = 1'b0;
            repeat (g) begin
                bus.ld_data = 8'($urandom);
                tick;
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = b;
            check("ld_ready_byte", bus.ld_ready, 1);
            tick;
            model[i] = b;
        end
        bus.ld_data = 8'($urandom);
        check("ld_ready_done", bus.ld_ready, 0);
        check("cpu_rst_before_run", bus.cpu_rst, 0);
        tick;
        bus.ld_valid = 1'b0;
        check("cpu_rst_run", bus.cpu_rst, 1);
        check("busy_in_run", bus.ld_busy, 0);
    endtask

    initial begin
        int n;
        bus.cpu_adress  = '0;
        bus.cpu_dataout = '0;
        bus.cpu_oe      = 1'b1;
        bus.cpu_we      = 1'b1;
        bus.ld_start    = 1'b0;
        bus.ld_len      = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_data     = '0;

        rst = 1'b0;
        repeat (2) tick;
        check("rst_cpu_rst", bus.cpu_rst, 0);
        check("rst_ld_ready", bus.ld_ready, 0);
        check("rst_ld_busy", bus.ld_busy, 0);
        check("rst_io_out", bus.io_out, 0);
        check("rst_io_stb", bus.io_stb, 0);
        rst = 1'b1;
        repeat (10) tick;
        check("idle_cpu_rst", bus.cpu_rst, 0);
        check("idle_ld_ready", bus.ld_ready, 0);
        check("idle_ld_busy", bus.ld_busy, 0);
        check("idle_io_out", bus.io_out, 0);

        ld_bytes = '{8'h3E, 8'h7F, 8'hC0};
        ld_gaps  = '{0, 2, 5};
        do_load(3, 1'b1, 1'b0, 8'h00);
        verify_all();

        cpu_store(63, 8'hA5, 1'b1);
        check("io_out_a5", bus.io_out, 8'hA5);
        for (int k = 0; k < 12; k++) begin
            cpu_store(int'($urandom_range(0, 63)), 8'($urandom), 1'b1);
        end
        verify_all();

        ld_bytes.delete();
        ld_gaps.delete();
        do_load(0, 1'b0, 1'b1, 8'h99);
        check("io_out_hold", bus.io_out, 8'h99);
        verify_all();

        do_load(100, 1'b0, 1'b0, 8'h00);
        verify_all();
        for (int k = 0; k < 2; k++) begin
            do_load(int'($urandom_range(1, 80)), 1'b0, 1'b0, 8'h00);
            verify_all();
        end

        // Reset in the middle of a load.
        bus.ld_start = 1'b1;
        bus.ld_len   = 7'd4;
        tick;
        bus.ld_start = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        n = 0;
        while (bus.ld_ready !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        check("abort_clear_cycles", n, 64);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h11;
        tick;
        model[0] = 8'h11;
        bus.ld_valid = 1'b0;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check("abort_ld_ready", bus.ld_ready, 0);
        check("abort_cpu_rst", bus.cpu_rst, 0);
        check("abort_ld_busy", bus.ld_busy, 0);
        check("abort_io_out", bus.io_out, 0);
        cpu_store(10, 8'hEE, 1'b0);
        verify_all();

        ld_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_load(4, 1'b0, 1'b0, 8'h00);
        verify_all();

        repeat (3) tick;
        check("io_q_drained", io_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcpu_memsys.md
Name: mcpu_memsys

Overview:
- Memory and boot subsystem on the data side of the mcpu core.
- Provides the core's 64x8 unified program/data RAM with asynchronous read and synchronous write.
- Loads a program image over a byte-wide valid/ready port and holds the core in reset until loading completes.
- Maps one address as an output port (io_out) for the tile pins.

Parameters:
AW, 6, address width; memory depth is 2**AW = 64
DW, 8, data width
IO_ADDR, 63, address whose CPU writes also update io_out
CLEAR_EN, 1, 1 = zero the whole RAM before each load; 0 = skip the CLEAR state

Ports:
clk  in  1  system clock, shared with the core
rst  in  1  reset, synchronous, active-low
cpu_rst  out  1  active-low reset to the core; 0 except in RUN
cpu_adress  in  AW  core address bus
cpu_dataout  in  DW  core write data
cpu_oe  in  1  core read strobe, active-low, clk-gated
cpu_we  in  1  core write strobe, active-low, clk-gated
cpu_datain  out  DW  read data to the core
ld_start  in  1  single-cycle pulse that starts a (re)load
ld_len  in  AW+1  number of bytes to load, 0..64; sampled with ld_start
ld_valid  in  1  loader byte valid
ld_data  in  DW  loader byte
ld_ready  out  1  block accepts a byte this cycle
ld_busy  out  1  high in CLEAR and LOAD
io_out  out  DW  output port register
io_stb  out  1  one-cycle pulse after each io_out update

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE, cpu_rst=0, ld_ready=0, ld_busy=0, io_out=0, io_stb=0, address counter=0, length register=0. RAM contents are not reset. Reset mid-CLEAR or mid-LOAD aborts to IDLE and drops the partial image.
- Strobe qualification:
  - A CPU write commits on a rising clk edge where cpu_we was low in the preceding clk-low phase and state=RUN.
  - Implementation: a rising-edge flop samples cpu_we, cpu_adress and cpu_dataout. Strobes settle after the edge, so the flop sees the pre-edge (clk-low) value.
  - Benches drive strobes with #1 after clk edges.
  - cpu_oe is not used for gating; reads are always enabled.
- cpu_datain = RAM[cpu_adress], combinational, in every state. Reads of IO_ADDR return the RAM copy.
- FSM:
  - IDLE: ld_start -> CLEAR if CLEAR_EN, else LOAD. Latch ld_len, counter=0.
  - CLEAR: write 0 to RAM[counter] each cycle. Exactly 64 cycles, then counter=0 and go to LOAD.
  - LOAD:
    - ld_ready=1 while counter<len.
    - On ld_valid&ld_ready: RAM[counter]<=ld_data, counter++.
    - When counter==len, go to RUN on the next edge; ld_ready is 0 in that cycle.
    - len=0 goes to RUN immediately.
    - len>64 is clamped to 64.
  - RUN: cpu_rst=1, registered, rising on the edge that enters RUN.
    - ld_start in RUN -> CLEAR/LOAD with cpu_rst=0 from the next edge. A CPU write committing on that same edge still lands.
- ld_start is ignored in CLEAR and LOAD.
- ld_busy=1 in CLEAR and LOAD.
- IO write: a committed CPU write with address==IO_ADDR also updates io_out on the same edge; io_stb=1 for exactly the following cycle. Back-to-back IO writes are impossible (the core needs at least 2 cycles per store) and require no handling.
- Counter is AW+1 bits, so it counts 0..64 without wrap; RAM index is counter[AW-1:0].

Decomposition:
- Package mcpu_pkg: AW, DW, IO_ADDR defaults, and the state enum {IDLE, CLEAR, LOAD, RUN}.
- Sub-module mcpu_ram64:
  - async read port, one synchronous write port, no reset
  - the top muxes between loader/clear writes and CPU writes by state, so writes never conflict.

Test Plan:
- Reset, then hold ld_start=0 for 10 cycles -> cpu_rst=0, ld_ready=0, io_out=0, state IDLE.
- ld_start with ld_len=3, CLEAR_EN=1:
  - ld_busy=1 for 64 cycles of CLEAR, then LOAD with ld_ready=1.
  - Bytes 0x3E,0x7F,0xC0 accepted; RAM[0..2] hold them, RAM[3..63]=0.
  - cpu_rst rises the edge after the third accept.
- Loader stalls (ld_valid gaps of 0,2,5 cycles) -> only valid&ready cycles advance the counter; exactly 3 bytes are stored.
- In RUN, model a core store of 0xA5 to address 63 (cpu_we low, #1 timing) -> io_out=0xA5 after the edge, io_stb high for 1 cycle, RAM[63]=0xA5, cpu_datain=0xA5 when cpu_adress=63.
- ld_start during RUN with ld_len=0 -> cpu_rst=0 next cycle, RAM cleared, RUN re-entered after 64+1 cycles.
- Assert rst mid-LOAD after 1 of 4 bytes -> IDLE next edge, ld_ready=0, cpu_rst=0; a later ld_start restarts loading at address 0.
